// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-channel PWM peripheral.
// Build option: PWM_DUTY_SHADOW_EN (consumed in pwm_peripheral).
package pwm_pkg;

  localparam int                 PWM_STEPS = 255;
  localparam int                 DUTY_W    = 8;
  localparam int                 NUM_CH    = 16;
  localparam logic [DUTY_W-1:0]  DUTY_FULL = 8'hFF;
  localparam logic [DUTY_W-1:0]  CNT_LAST  = DUTY_W'(PWM_STEPS - 1);

  // Full-scale duty is special-cased so the output never dips low at the wrap.
  function automatic logic pwm_level_f(input logic [DUTY_W-1:0] cnt,
                                       input logic [DUTY_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: clock prescaler, step counter 0..PWM_STEPS-1 and the
// registered period_start pulse issued in the cycle after the counter wraps.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic [DUTY_W-1:0] pwm_cnt_o,
  output logic              wrap_o,
  output logic              period_start_o
);

  localparam int               PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              ps_q, ps_d;
  logic              step_tick;
  logic              cnt_last;

  // With CLK_DIV == 1 the prescaler is stuck at 0 and step_tick is always high.
  assign step_tick = (pre_q == PRE_LAST);
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign wrap_o    = step_tick & cnt_last;

  always_comb begin
    pre_d = step_tick ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    if (step_tick) begin
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
    end
    ps_d = wrap_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  assign pwm_cnt_o      = cnt_q;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage driven by the SPI register file.
// `define PWM_DUTY_SHADOW_EN to latch the duty only at the period wrap.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [DUTY_W-1:0]   pwm_duty_cycle,
  output logic [NUM_CH-1:0]   out,
  output logic                period_start
);

  logic [DUTY_W-1:0] pwm_cnt;
  logic              wrap;
  logic [DUTY_W-1:0] duty_active;
  logic              pwm_level;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [NUM_CH-1:0] out_q, out_d;

  pwm_timebase #(
    .CLK_DIV (CLK_DIV)
  ) u_timebase (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .pwm_cnt_o      (pwm_cnt),
    .wrap_o         (wrap),
    .period_start_o (period_start)
  );

`ifdef PWM_DUTY_SHADOW_EN
  logic [DUTY_W-1:0] duty_q, duty_d;

  // Loading only at the wrap keeps every period whole: no runt pulses.
  always_comb begin
    duty_d = duty_q;
    if (wrap) begin
      duty_d = pwm_duty_cycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else begin
      duty_q <= duty_d;
    end
  end

  assign duty_active = duty_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign duty_active = pwm_duty_cycle;
`endif

  assign pwm_level = pwm_level_f(pwm_cnt, duty_active);
  assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en_out[i]) begin
        out_d[i] = en_pwm[i] ? pwm_level : 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized self-checking bench for pwm_peripheral against a time-based model.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 13;
  localparam int STEPS   = 255;
  localparam int PER     = CLK_DIV * STEPS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0 = '0;
  logic [7:0]  en_reg_out_15_8 = '0;
  logic [7:0]  en_reg_pwm_7_0 = '0;
  logic [7:0]  en_reg_pwm_15_8 = '0;
  logic [7:0]  pwm_duty_cycle = '0;
  logic [15:0] out;
  logic        period_start;

  int          checks = 0;
  int          failures = 0;
  int          t = 0;
  logic [7:0]  shadow_m = '0;
  int          hi_cnt;
  int          ps_cnt;
  int          n;

  always #50 clk = ~clk;

  pwm_peripheral #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Pin value straight from the per-bit rules, given the step index and duty in force.
  function automatic logic [15:0] ref_out(input logic [15:0] eo, input logic [15:0] ep,
                                          input logic [7:0] duty, input int step);
    logic [15:0] r;
    logic        lvl;
    lvl = (duty == 8'hFF) ? 1'b1 : (step < int'(duty));
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])      r[i] = 1'b0;
      else if (!ep[i]) r[i] = 1'b1;
      else             r[i] = lvl;
    end
    return r;
  endfunction

  // Advance one clock; t counts rising edges since reset release.
  task automatic tick();
    logic [15:0] eo, ep, m_out;
    logic [7:0]  duty_in, duty_eff;
    logic        m_ps;
    int          step;
    eo      = {en_reg_out_15_8, en_reg_out_7_0};
    ep      = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    duty_in = pwm_duty_cycle;
    step    = (t / CLK_DIV) % STEPS;
`ifdef PWM_DUTY_SHADOW_EN
    duty_eff = shadow_m;
`else
    duty_eff = duty_in;
`endif
    m_out = ref_out(eo, ep, duty_eff, step);
    @(posedge clk);
    #1;
    t++;
    m_ps = (t % PER == 0);
`ifdef PWM_DUTY_SHADOW_EN
    if (m_ps) shadow_m = duty_in;
`endif
    check_val("out", 32'(out), 32'(m_out));
    check_val("period_start", 32'(period_start), 32'(m_ps));
  endtask

  task automatic wait_ps();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!period_start && k < PER + 20);
    check_val("ps_wait", 32'(period_start), 32'd1);
  endtask

  task automatic measure_high(input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out[0]) hi++;
    end
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  initial begin
    // Reset, enables off, duty 0x80
    pwm_duty_cycle = 8'h80;
    repeat (3) @(negedge clk);
    check_val("rst_out", 32'(out), 32'h0);
    check_val("rst_ps", 32'(period_start), 32'h0);
    rst_n = 1'b1;
    t = 0;
    shadow_m = '0;

    ps_cnt = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      if (period_start) ps_cnt++;
    end
    check_val("ps_count_3per", 32'(ps_cnt), 32'd3);

    // Static high on all pins, one clock latency
    set_en(16'hFFFF, 16'h0000);
    tick();
    check_val("static_high", 32'(out), 32'hFFFF);
    repeat (5) tick();

    // Channel 0 PWM at duty 0x80
    set_en(16'h0001, 16'h0001);
    wait_ps();
    measure_high(PER, hi_cnt);
    check_val("duty80_high", 32'(hi_cnt), 32'(128 * CLK_DIV));
    check_val("upper_zero", 32'(out[15:1]), 32'h0);

    // Duty 0: constant low
    pwm_duty_cycle = 8'h00;
    wait_ps();
    measure_high(PER, hi_cnt);
    check_val("duty00_high", 32'(hi_cnt), 32'd0);

    // Duty 0xFF: constant high across the wrap
    pwm_duty_cycle = 8'hFF;
    wait_ps();
    measure_high(2 * PER, hi_cnt);
    check_val("dutyFF_high", 32'(hi_cnt), 32'(2 * PER));

    // Mid-period duty change at step 100
    pwm_duty_cycle = 8'h40;
    wait_ps();
    measure_high(100 * CLK_DIV, hi_cnt);
    pwm_duty_cycle = 8'hC0;
    tick();
    if (out[0]) hi_cnt++;
`ifdef PWM_DUTY_SHADOW_EN
    check_val("chg_first_clk", 32'(out[0]), 32'd0);
`else
    check_val("chg_first_clk", 32'(out[0]), 32'd1);
`endif
    n = hi_cnt;
    measure_high(PER - 100 * CLK_DIV - 1, hi_cnt);
    n += hi_cnt;
`ifdef PWM_DUTY_SHADOW_EN
    check_val("chg_cur_period", 32'(n), 32'(64 * CLK_DIV));
`else
    check_val("chg_cur_period", 32'(n), 32'(64 * CLK_DIV + 92 * CLK_DIV));
`endif
    measure_high(PER, hi_cnt);
    check_val("chg_next_period", 32'(hi_cnt), 32'(192 * CLK_DIV));

    // Reset at step 200 with out[0] high
    pwm_duty_cycle = 8'hFF;
    wait_ps();
    repeat (200 * CLK_DIV + 5) tick();
    check_val("pre_rst_high", 32'(out[0]), 32'd1);
    #10;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out", 32'(out), 32'h0);
    check_val("midrst_ps", 32'(period_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    shadow_m = '0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!period_start && n < PER + 50);
    check_val("first_ps_after_rst", 32'(n), 32'(PER));

    // Random enables and duty
    for (int i = 0; i < 12000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        set_en(16'($urandom), 16'($urandom));
        case ($urandom_range(0, 3))
          0:       pwm_duty_cycle = 8'h00;
          1:       pwm_duty_cycle = 8'hFF;
          default: pwm_duty_cycle = 8'($urandom);
        endcase
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
